// File: rtl/riscv_multicycle_ctrl.sv
// Multicycle sequencer: FETCH/DECODE/EXEC/MEM/WB control for the core datapath.
// Ports: imem/dmem req-ready, IR-derived datapath strobes, state, flags, retire count.
module riscv_multicycle_ctrl #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [31:0]      instr,
    output logic             imem_req,
    input  logic             imem_ready,
    output logic             dmem_req,
    output logic             dmem_we,
    input  logic             dmem_ready,
    input  logic             alu_zero_flag,
    input  logic             last_instr_flag,
    output logic             ir_write_en,
    output logic             pc_write_en,
    output logic [1:0]       pc_sel,
    output logic             reg_write_en,
    output logic             alu_src_b,
    output logic [1:0]       mem_to_reg_sel,
    output logic [3:0]       alu_op,
    output logic [2:0]       state_out,
    output logic             finish_flag,
    output logic             error_flag,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC,
        S_MEM, S_WB, S_HALT, S_ERROR
    } state_t;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LD   = 7'b0000011;
    localparam logic [6:0] OP_ST   = 7'b0100011;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_LUI  = 7'b0110111;

    localparam logic [3:0] A_ADD  = 4'd0;
    localparam logic [3:0] A_SUB  = 4'd1;
    localparam logic [3:0] A_AND  = 4'd2;
    localparam logic [3:0] A_OR   = 4'd3;
    localparam logic [3:0] A_XOR  = 4'd4;
    localparam logic [3:0] A_SLL  = 4'd5;
    localparam logic [3:0] A_SRL  = 4'd6;
    localparam logic [3:0] A_SRA  = 4'd7;
    localparam logic [3:0] A_SLT  = 4'd8;
    localparam logic [3:0] A_SLTU = 4'd9;
    localparam logic [3:0] A_PASS = 4'd10;

    localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WW-1:0] LIM = WW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_t          state, nx;
    logic [31:0]     ir;
    logic [WW-1:0]   wait_cnt;
    logic            retire;
    logic            timeout_hit;

    logic [6:0] opc;
    logic [2:0] f3;
    logic       f7b5;
    logic       is_r, is_i, is_ld, is_st, is_br, is_jal, is_jalr, is_lui;
    logic       legal, taken;
    logic [3:0] f3_op, dec_op;
    logic       unused_ir;

    assign opc  = ir[6:0];
    assign f3   = ir[14:12];
    assign f7b5 = ir[30];
    assign unused_ir = ^{ir[31], ir[29:15], ir[11:7]};

    assign is_r    = (opc == OP_R);
    assign is_i    = (opc == OP_I);
    assign is_ld   = (opc == OP_LD);
    assign is_st   = (opc == OP_ST);
    assign is_br   = (opc == OP_BR) && (f3[2:1] == 2'b00);
    assign is_jal  = (opc == OP_JAL);
    assign is_jalr = (opc == OP_JALR);
    assign is_lui  = (opc == OP_LUI);
    assign legal   = is_r | is_i | is_ld | is_st | is_br
                   | is_jal | is_jalr | is_lui;

    // BEQ (f3=000) takes on zero, BNE (f3=001) on non-zero
    assign taken = f3[0] ? ~alu_zero_flag : alu_zero_flag;

    assign timeout_hit = (TIMEOUT != 0) && (wait_cnt == LIM);
    assign state_out   = state;

    // funct7[5] only selects SUB for R-type; I-type imm bit 30 is data
    always_comb begin
        f3_op = A_ADD;
        case (f3)
            3'b000:  f3_op = (is_r && f7b5) ? A_SUB : A_ADD;
            3'b001:  f3_op = A_SLL;
            3'b010:  f3_op = A_SLT;
            3'b011:  f3_op = A_SLTU;
            3'b100:  f3_op = A_XOR;
            3'b101:  f3_op = f7b5 ? A_SRA : A_SRL;
            3'b110:  f3_op = A_OR;
            default: f3_op = A_AND;
        endcase
    end

    always_comb begin
        dec_op = A_ADD;
        unique case (1'b1)
            is_r, is_i: dec_op = f3_op;
            is_br:      dec_op = A_SUB;
            is_lui:     dec_op = A_PASS;
            default:    dec_op = A_ADD;
        endcase
    end

    always_comb begin
        nx             = state;
        retire         = 1'b0;
        imem_req       = 1'b0;
        ir_write_en    = 1'b0;
        dmem_req       = 1'b0;
        dmem_we        = 1'b0;
        pc_write_en    = 1'b0;
        pc_sel         = 2'b00;
        reg_write_en   = 1'b0;
        alu_src_b      = 1'b0;
        mem_to_reg_sel = 2'b00;
        alu_op         = A_ADD;
        case (state)
            S_IDLE: if (start) nx = S_FETCH;
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    ir_write_en = 1'b1;
                    nx          = S_DECODE;
                end else if (timeout_hit) begin
                    nx = S_ERROR;
                end
            end
            S_DECODE: nx = legal ? S_EXEC : S_ERROR;
            S_EXEC: begin
                alu_op    = dec_op;
                alu_src_b = ~(is_r | is_br | is_jal);
                unique case (1'b1)
                    is_ld, is_st: nx = S_MEM;
                    is_br: begin
                        pc_write_en = 1'b1;
                        pc_sel      = taken ? 2'b01 : 2'b00;
                        retire      = 1'b1;
                    end
                    is_jal, is_jalr: begin
                        pc_write_en    = 1'b1;
                        pc_sel         = is_jal ? 2'b01 : 2'b10;
                        reg_write_en   = 1'b1;
                        mem_to_reg_sel = 2'b10;
                        retire         = 1'b1;
                    end
                    default: nx = S_WB;
                endcase
            end
            S_MEM: begin
                dmem_req = 1'b1;
                if (dmem_ready) begin
                    if (is_st) begin
                        dmem_we     = 1'b1;
                        pc_write_en = 1'b1;
                        retire      = 1'b1;
                    end else begin
                        nx = S_WB;
                    end
                end else if (timeout_hit) begin
                    nx = S_ERROR;
                end
            end
            S_WB: begin
                reg_write_en   = 1'b1;
                mem_to_reg_sel = is_ld ? 2'b01 : 2'b00;
                pc_write_en    = 1'b1;
                retire         = 1'b1;
            end
            default: nx = state;
        endcase
        if (retire) nx = last_instr_flag ? S_HALT : S_FETCH;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            ir          <= '0;
            wait_cnt    <= '0;
            instr_count <= '0;
            finish_flag <= 1'b0;
            error_flag  <= 1'b0;
        end else begin
            state <= nx;
            if (ir_write_en) ir <= instr;
            if (retire) instr_count <= instr_count + CNT_W'(1);
            if (nx == S_HALT) finish_flag <= 1'b1;
            if (nx == S_ERROR) error_flag <= 1'b1;
            if (nx != state && (nx == S_FETCH || nx == S_MEM))
                wait_cnt <= '0;
            else if (nx == state && TIMEOUT != 0 &&
                     ((state == S_FETCH && !imem_ready) ||
                      (state == S_MEM && !dmem_ready)))
                wait_cnt <= wait_cnt + WW'(1);
        end
    end

endmodule

// File: tb/tb_riscv_multicycle_ctrl.sv
// Scoreboard bench for riscv_multicycle_ctrl: scripted per-cycle expectations.
// Covers ALU/LUI, load/store waits, branches, jumps, halt, timeout, illegal, reset.
module tb_riscv_multicycle_ctrl;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] instr;
    logic        imem_req, imem_ready;
    logic        dmem_req, dmem_we, dmem_ready;
    logic        alu_zero_flag, last_instr_flag;
    logic        ir_write_en, pc_write_en;
    logic [1:0]  pc_sel;
    logic        reg_write_en, alu_src_b;
    logic [1:0]  mem_to_reg_sel;
    logic [3:0]  alu_op;
    logic [2:0]  state_out;
    logic        finish_flag, error_flag;
    logic [31:0] instr_count;

    riscv_multicycle_ctrl #(.TIMEOUT(16), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .start(start), .instr(instr),
        .imem_req(imem_req), .imem_ready(imem_ready),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ready(dmem_ready),
        .alu_zero_flag(alu_zero_flag), .last_instr_flag(last_instr_flag),
        .ir_write_en(ir_write_en), .pc_write_en(pc_write_en),
        .pc_sel(pc_sel), .reg_write_en(reg_write_en),
        .alu_src_b(alu_src_b), .mem_to_reg_sel(mem_to_reg_sel),
        .alu_op(alu_op), .state_out(state_out),
        .finish_flag(finish_flag), .error_flag(error_flag),
        .instr_count(instr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] st;
        logic       ireq, irw, dreq, dwe, pcw;
        logic [1:0] pcs;
        logic       rw;
        logic [1:0] mtr;
        logic       adc;
        logic [3:0] aop;
        logic       asb;
    } exp_t;

    exp_t sb[$];
    int   nvec = 0;
    int   nmis = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)",
                     tag, got, exp, $time);
        end
    endtask

    function automatic exp_t f_base(input logic [2:0] st,
                                    input logic adc);
        exp_t e;
        e     = '0;
        e.st  = st;
        e.adc = adc;
        return e;
    endfunction

    function automatic exp_t f_fetch(input logic r);
        exp_t e;
        e      = f_base(3'd1, 1'b1);
        e.ireq = 1'b1;
        e.irw  = r;
        return e;
    endfunction

    function automatic exp_t f_exec(input logic [3:0] op,
                                    input logic asb);
        exp_t e;
        e     = f_base(3'd3, 1'b0);
        e.aop = op;
        e.asb = asb;
        return e;
    endfunction

    function automatic exp_t f_mem(input logic r, input logic s);
        exp_t e;
        e      = f_base(3'd4, 1'b1);
        e.dreq = 1'b1;
        e.dwe  = r & s;
        e.pcw  = r & s;
        return e;
    endfunction

    function automatic exp_t f_wb(input logic [1:0] m);
        exp_t e;
        e     = f_base(3'd5, 1'b1);
        e.rw  = 1'b1;
        e.pcw = 1'b1;
        e.mtr = m;
        return e;
    endfunction

    // one clock: queue expectation, compare at negedge, step to posedge+1
    task automatic cyc(input exp_t e);
        exp_t x;
        sb.push_back(e);
        @(negedge clk);
        if (sb.size() == 0) begin
            chk("sb_empty", 64'd0, 64'd1);
        end else begin
            x = sb.pop_front();
            chk("state", state_out, x.st);
            chk("imem_req", imem_req, x.ireq);
            chk("ir_write_en", ir_write_en, x.irw);
            chk("dmem_req", dmem_req, x.dreq);
            chk("dmem_we", dmem_we, x.dwe);
            chk("pc_write_en", pc_write_en, x.pcw);
            chk("pc_sel", pc_sel, x.pcs);
            chk("reg_write_en", reg_write_en, x.rw);
            chk("mem_to_reg_sel", mem_to_reg_sel, x.mtr);
            if (!x.adc) begin
                chk("alu_op", alu_op, x.aop);
                chk("alu_src_b", alu_src_b, x.asb);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic fetch_dec(input logic [31:0] w);
        instr      = w;
        imem_ready = 1'b1;
        cyc(f_fetch(1'b1));
        instr = 32'hFFFF_FFFF;
        cyc(f_base(3'd2, 1'b1));
    endtask

    task automatic do_alu(input logic [31:0] w, input logic [3:0] op,
                          input logic asb);
        fetch_dec(w);
        cyc(f_exec(op, asb));
        cyc(f_wb(2'b00));
    endtask

    task automatic do_branch(input logic [31:0] w, input logic z,
                             input logic [1:0] ps);
        exp_t e;
        fetch_dec(w);
        e     = f_exec(4'd1, 1'b0);
        e.pcw = 1'b1;
        e.pcs = ps;
        alu_zero_flag = z;
        cyc(e);
        alu_zero_flag = 1'b0;
    endtask

    task automatic do_reset;
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk(tag, {imem_req, dmem_req, dmem_we, ir_write_en, pc_write_en,
                  pc_sel, reg_write_en, alu_src_b, mem_to_reg_sel, alu_op,
                  state_out, finish_flag, error_flag}, 64'd0);
        chk({tag, "_cnt"}, instr_count, 64'd0);
    endtask

    exp_t e;

    initial begin
        rst = 1'b0; start = 1'b0; instr = '0;
        imem_ready = 1'b0; dmem_ready = 1'b0;
        alu_zero_flag = 1'b0; last_instr_flag = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_all_zero("reset");
        @(posedge clk);
        #1;
        rst = 1'b1;

        // add, then ALU variants with ready tied high
        start = 1'b1;
        dmem_ready = 1'b1;
        cyc(f_base(3'd0, 1'b0));
        start = 1'b0;
        do_alu(32'h002081B3, 4'd0, 1'b0);
        chk("cnt_add", instr_count, 64'd1);
        do_alu(32'h402081B3, 4'd1, 1'b0);
        do_alu(32'h40008093, 4'd0, 1'b1);
        do_alu(32'h4020D1B3, 4'd7, 1'b0);
        do_alu(32'h4010D093, 4'd7, 1'b1);
        do_alu(32'h123450B7, 4'd10, 1'b1);
        do_alu(32'h0020B1B3, 4'd9, 1'b0);
        chk("cnt_alu", instr_count, 64'd7);

        // lw with three data wait cycles
        fetch_dec(32'h0000A183);
        cyc(f_exec(4'd0, 1'b1));
        dmem_ready = 1'b0;
        repeat (3) cyc(f_mem(1'b0, 1'b0));
        dmem_ready = 1'b1;
        cyc(f_mem(1'b1, 1'b0));
        cyc(f_wb(2'b01));
        chk("cnt_lw", instr_count, 64'd8);

        // sw with one wait cycle
        fetch_dec(32'h0020A023);
        cyc(f_exec(4'd0, 1'b1));
        dmem_ready = 1'b0;
        cyc(f_mem(1'b0, 1'b1));
        dmem_ready = 1'b1;
        cyc(f_mem(1'b1, 1'b1));
        chk("cnt_sw", instr_count, 64'd9);

        do_branch(32'h00208463, 1'b1, 2'b01);
        do_branch(32'h00208463, 1'b0, 2'b00);
        do_branch(32'h00209463, 1'b0, 2'b01);
        do_branch(32'h00209463, 1'b1, 2'b00);
        chk("cnt_br", instr_count, 64'd13);

        // jalr
        fetch_dec(32'h000100E7);
        e     = f_exec(4'd0, 1'b1);
        e.pcw = 1'b1; e.pcs = 2'b10; e.rw = 1'b1; e.mtr = 2'b10;
        cyc(e);

        // jal marked last -> HALT
        fetch_dec(32'h000000EF);
        e     = f_base(3'd3, 1'b1);
        e.pcw = 1'b1; e.pcs = 2'b01; e.rw = 1'b1; e.mtr = 2'b10;
        last_instr_flag = 1'b1;
        cyc(e);
        last_instr_flag = 1'b0;
        chk("finish_set", finish_flag, 64'd1);
        chk("cnt_jal", instr_count, 64'd15);
        start = 1'b1;
        cyc(f_base(3'd6, 1'b0));
        start = 1'b0;
        cyc(f_base(3'd6, 1'b0));
        chk("finish_sticky", finish_flag, 64'd1);
        chk("halt_no_err", error_flag, 64'd0);

        // fetch timeout
        do_reset();
        chk("rst_finish", finish_flag, 64'd0);
        start = 1'b1;
        imem_ready = 1'b0;
        cyc(f_base(3'd0, 1'b0));
        start = 1'b0;
        repeat (16) cyc(f_fetch(1'b0));
        chk("err_timeout", error_flag, 64'd1);
        start = 1'b1;
        cyc(f_base(3'd7, 1'b0));
        start = 1'b0;
        cyc(f_base(3'd7, 1'b0));
        chk("err_sticky", error_flag, 64'd1);

        // ready on the limit cycle wins, then illegal word
        do_reset();
        chk("rst_error", error_flag, 64'd0);
        start = 1'b1;
        cyc(f_base(3'd0, 1'b0));
        start = 1'b0;
        repeat (15) cyc(f_fetch(1'b0));
        do_alu(32'h002081B3, 4'd0, 1'b0);
        chk("limit_no_err", error_flag, 64'd0);
        fetch_dec(32'hFFFF_FFFF);
        cyc(f_base(3'd7, 1'b0));
        chk("err_illegal", error_flag, 64'd1);
        chk("cnt_illegal", instr_count, 64'd1);

        // unsupported branch funct3
        do_reset();
        start = 1'b1;
        cyc(f_base(3'd0, 1'b0));
        start = 1'b0;
        fetch_dec(32'h0020C463);
        cyc(f_base(3'd7, 1'b0));
        chk("err_blt", error_flag, 64'd1);

        // reset while a store waits in MEM
        do_reset();
        start = 1'b1;
        dmem_ready = 1'b1;
        cyc(f_base(3'd0, 1'b0));
        start = 1'b0;
        do_alu(32'h002081B3, 4'd0, 1'b0);
        fetch_dec(32'h0020A023);
        cyc(f_exec(4'd0, 1'b1));
        dmem_ready = 1'b0;
        cyc(f_mem(1'b0, 1'b1));
        rst = 1'b0;
        #1;
        chk_all_zero("mid_rst");
        @(posedge clk);
        #1;
        rst = 1'b1;
        dmem_ready = 1'b1;
        cyc(f_base(3'd0, 1'b0));
        chk("post_rst_cnt", instr_count, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
